// File: rtl/mure_pkg.sv
// Shared widths, bundle record and scheduler state for the MURE retire path.
// The bundle is sized for the widest supported commit width; narrower configurations zero the upper lanes.
package mure_pkg;

   localparam int XLEN            = 32;
   localparam int ITYPE_LEN       = 3;
   localparam int CAUSE_LEN       = 5;
   localparam int PRIV_LEN        = 2;
   localparam int MaxRetiredInstr = 4;
   localparam int LaneIdxW        = $clog2(MaxRetiredInstr);

   typedef enum logic {
      IDLE,
      DRAIN
   } sched_state_e;

   typedef struct packed {
      logic [MaxRetiredInstr-1:0]                iretire;
      logic [MaxRetiredInstr-1:0]                ilastsize;
      logic [MaxRetiredInstr-1:0][ITYPE_LEN-1:0] itype;
      logic [MaxRetiredInstr-1:0][XLEN-1:0]      iaddr;
      logic [CAUSE_LEN-1:0]                      cause;
      logic [XLEN-1:0]                           tval;
      logic [PRIV_LEN-1:0]                       priv;
   } bundle_t;

   // Index of the lowest set bit; program order within a bundle is ascending lane index.
   function automatic logic [LaneIdxW-1:0] lowest_lane(input logic [MaxRetiredInstr-1:0] mask);
      lowest_lane = '0;
      for (int i = MaxRetiredInstr - 1; i >= 0; i--) begin
         if (mask[i]) lowest_lane = LaneIdxW'(i);
      end
   endfunction

endpackage

// File: rtl/mure_bundle_fifo.sv
// Generic synchronous FIFO with a combinational head; a push into a full FIFO succeeds when a pop
// happens in the same cycle. Depth must be a power of two, at least 2.
module mure_bundle_fifo #(
   parameter type         T     = logic,
   parameter int unsigned Depth = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output logic full_o,
   output logic empty_o,
   output logic one_left_o,
   output T     head_o
);

   localparam int unsigned AddrW = $clog2(Depth);
   localparam logic [AddrW:0] PtrOne = 1;

   logic [AddrW:0] wr_ptr;
   logic [AddrW:0] rd_ptr;
   logic           write_en;
   logic           read_en;
   T               mem [Depth];

   // Extra pointer MSB separates full from empty when the address bits match.
   assign full_o     = (wr_ptr[AddrW] != rd_ptr[AddrW]) && (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);
   assign empty_o    = (wr_ptr == rd_ptr);
   assign one_left_o = ((wr_ptr - rd_ptr) == PtrOne);
   assign head_o     = mem[rd_ptr[AddrW-1:0]];

   assign write_en = push_i && (!full_o || pop_i);
   assign read_en  = pop_i && !empty_o;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (write_en) wr_ptr <= wr_ptr + PtrOne;
         if (read_en)  rd_ptr <= rd_ptr + PtrOne;
      end
   end

   // NOTE: storage has no reset; only entries between the reset pointers are ever read.
   always_ff @(posedge clk_i) begin
      if (write_en) mem[wr_ptr[AddrW-1:0]] <= data_i;
   end

endmodule

// File: rtl/mure_retire_scheduler.sv
// Serialises CVA6 commit bundles into one instruction per cycle with valid/ready backpressure.
// Optional MURE_DROP_CNT_EN adds a saturating 16-bit dropped-bundle counter on drop_cnt_o.
module mure_retire_scheduler
   import mure_pkg::*;
#(
   parameter int NrRetiredInstr = 2,
   parameter int FifoDepth      = 4
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic [NrRetiredInstr-1:0]                iretire_i,
   input  logic [NrRetiredInstr-1:0]                ilastsize_i,
   input  logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0] itype_i,
   input  logic [CAUSE_LEN-1:0]                     cause_i,
   input  logic [XLEN-1:0]                          tval_i,
   input  logic [PRIV_LEN-1:0]                      priv_i,
   input  logic [NrRetiredInstr-1:0][XLEN-1:0]      iaddr_i,
   output logic                                     valid_o,
   input  logic                                     ready_i,
   output logic                                     ilastsize_o,
   output logic [ITYPE_LEN-1:0]                     itype_o,
   output logic [CAUSE_LEN-1:0]                     cause_o,
   output logic [XLEN-1:0]                          tval_o,
   output logic [PRIV_LEN-1:0]                      priv_o,
   output logic [XLEN-1:0]                          iaddr_o,
   output logic                                     empty_o,
   output logic                                     overflow_o,
`ifdef MURE_DROP_CNT_EN
   output logic [15:0]                              drop_cnt_o,
`endif
   input  logic                                     clear_overflow_i
);

   sched_state_e               state_q;
   bundle_t                    bundle_in;
   bundle_t                    head;
   logic                       push_req;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       fifo_one_left;
   logic [MaxRetiredInstr-1:0] done_q;
   logic [MaxRetiredInstr-1:0] pending;
   logic [MaxRetiredInstr-1:0] remaining;
   logic [LaneIdxW-1:0]        sel_idx;
   logic                       last_lane;
   logic                       can_load;
   logic                       issue;
   logic                       pop;
   logic                       drop;

   assign push_req = |iretire_i;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      bundle_in       = '0;
      bundle_in.cause = cause_i;
      bundle_in.tval  = tval_i;
      bundle_in.priv  = priv_i;
      for (int i = 0; i < NrRetiredInstr; i++) begin
         bundle_in.iretire[i]   = iretire_i[i];
         bundle_in.ilastsize[i] = ilastsize_i[i];
         bundle_in.itype[i]     = itype_i[i];
         bundle_in.iaddr[i]     = iaddr_i[i];
      end
   end

   mure_bundle_fifo #(
      .T     (bundle_t),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (push_req),
      .data_i     (bundle_in),
      .pop_i      (pop),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .one_left_o (fifo_one_left),
      .head_o     (head)
   );

   // The pending mask is the head's retire bits minus the lanes already issued from it.
   always_comb begin
      pending            = fifo_empty ? '0 : (head.iretire & ~done_q);
      sel_idx            = lowest_lane(pending);
      remaining          = pending;
      remaining[sel_idx] = 1'b0;
   end

   assign last_lane = (remaining == '0);
   assign can_load  = !valid_o || ready_i;
   assign issue     = (state_q == DRAIN) && can_load && (pending != '0);
   assign pop       = issue && last_lane;
   assign drop      = push_req && fifo_full && !pop;
   assign empty_o   = fifo_empty && !valid_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done_q <= '0;
      end else if (issue) begin
         done_q <= last_lane ? '0 : (head.iretire & ~remaining);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         valid_o     <= 1'b0;
         ilastsize_o <= 1'b0;
         itype_o     <= '0;
         cause_o     <= '0;
         tval_o      <= '0;
         priv_o      <= '0;
         iaddr_o     <= '0;
      end else begin
         case (state_q)
            IDLE:    if (push_req) state_q <= DRAIN;
            DRAIN:   if (pop && fifo_one_left && !push_req) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         // Fields are only rewritten on a new load, so they hold while the encoder stalls.
         if (can_load) begin
            valid_o <= issue;
            if (issue) begin
               ilastsize_o <= head.ilastsize[sel_idx];
               itype_o     <= head.itype[sel_idx];
               iaddr_o     <= head.iaddr[sel_idx];
               cause_o     <= head.cause;
               tval_o      <= head.tval;
               priv_o      <= head.priv;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_o <= 1'b0;
      end else if (drop) begin
         overflow_o <= 1'b1;
      end else if (clear_overflow_i) begin
         overflow_o <= 1'b0;
      end
   end

`ifdef MURE_DROP_CNT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drop_cnt_o <= '0;
      end else if (drop) begin
         if (clear_overflow_i)            drop_cnt_o <= 16'd1;
         else if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      end else if (clear_overflow_i) begin
         drop_cnt_o <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_mure_retire_scheduler.sv
// Directed bench for mure_retire_scheduler: scoreboard of expected instructions checked at each handshake.
module tb_mure_retire_scheduler;
   import mure_pkg::*;

   localparam int NR = 2;

   typedef struct packed {
      logic                 ls;
      logic [ITYPE_LEN-1:0] ty;
      logic [CAUSE_LEN-1:0] cause;
      logic [XLEN-1:0]      tval;
      logic [PRIV_LEN-1:0]  priv;
      logic [XLEN-1:0]      addr;
   } exp_t;

   logic                         clk;
   logic                         rst_n;
   logic [NR-1:0]                iretire;
   logic [NR-1:0]                ilastsize;
   logic [NR-1:0][ITYPE_LEN-1:0] itype;
   logic [CAUSE_LEN-1:0]         cause;
   logic [XLEN-1:0]              tval;
   logic [PRIV_LEN-1:0]          priv;
   logic [NR-1:0][XLEN-1:0]      iaddr;
   logic                         valid;
   logic                         ready;
   logic                         ilastsize_q;
   logic [ITYPE_LEN-1:0]         itype_q;
   logic [CAUSE_LEN-1:0]         cause_q;
   logic [XLEN-1:0]              tval_q;
   logic [PRIV_LEN-1:0]          priv_q;
   logic [XLEN-1:0]              iaddr_q;
   logic                         empty;
   logic                         overflow;
   logic                         clear_ovf;
`ifdef MURE_DROP_CNT_EN
   logic [15:0]                  drop_cnt;
`endif

   int   checks   = 0;
   int   failures = 0;
   exp_t sb [$];

   mure_retire_scheduler #(
      .NrRetiredInstr (NR),
      .FifoDepth      (4)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .iretire_i        (iretire),
      .ilastsize_i      (ilastsize),
      .itype_i          (itype),
      .cause_i          (cause),
      .tval_i           (tval),
      .priv_i           (priv),
      .iaddr_i          (iaddr),
      .valid_o          (valid),
      .ready_i          (ready),
      .ilastsize_o      (ilastsize_q),
      .itype_o          (itype_q),
      .cause_o          (cause_q),
      .tval_o           (tval_q),
      .priv_o           (priv_q),
      .iaddr_o          (iaddr_q),
      .empty_o          (empty),
      .overflow_o       (overflow),
`ifdef MURE_DROP_CNT_EN
      .drop_cnt_o       (drop_cnt),
`endif
      .clear_overflow_i (clear_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one bundle for a single cycle; lanes expected to survive are queued in program order.
   task automatic push(input logic [1:0] ret, input logic [1:0] ls,
                       input logic [ITYPE_LEN-1:0] ty0, input logic [ITYPE_LEN-1:0] ty1,
                       input logic [XLEN-1:0] a0, input logic [XLEN-1:0] a1,
                       input logic [CAUSE_LEN-1:0] c, input logic [XLEN-1:0] tv,
                       input logic [PRIV_LEN-1:0] pv, input bit keep);
      exp_t e;
      iretire   = ret;
      ilastsize = ls;
      itype[0]  = ty0;
      itype[1]  = ty1;
      iaddr[0]  = a0;
      iaddr[1]  = a1;
      cause     = c;
      tval      = tv;
      priv      = pv;
      if (keep) begin
         if (ret[0]) begin
            e = '{ls: ls[0], ty: ty0, cause: c, tval: tv, priv: pv, addr: a0};
            sb.push_back(e);
         end
         if (ret[1]) begin
            e = '{ls: ls[1], ty: ty1, cause: c, tval: tv, priv: pv, addr: a1};
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      iretire = '0;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (empty && sb.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check("drain_empty", 128'(empty), 128'(1));
      check("drain_sb_left", 128'(sb.size()), 128'(0));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accepted output instruction must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && valid && ready) begin
         checks++;
         assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL sb_unexpected observed=addr %0h expected=no instruction", iaddr_q);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_instr", {ilastsize_q, itype_q, cause_q, tval_q, priv_q, iaddr_q}, e);
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      iretire   = '0;
      ilastsize = '0;
      itype     = '0;
      cause     = '0;
      tval      = '0;
      priv      = '0;
      iaddr     = '0;
      ready     = 1'b1;
      clear_ovf = 1'b0;

      #1;
      check("rst_valid", 128'(valid), 128'(0));
      check("rst_empty", 128'(empty), 128'(1));
      check("rst_overflow", 128'(overflow), 128'(0));
      check("rst_fields", {itype_q, cause_q, tval_q, priv_q, iaddr_q, ilastsize_q}, 128'(0));
`ifdef MURE_DROP_CNT_EN
      check("rst_drop_cnt", 128'(drop_cnt), 128'(0));
`endif
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Two-lane bundle, no backpressure: first lane two cycles after input.
      push(2'b11, 2'b01, 3'd0, 3'd0, 32'h100, 32'h104, 5'd0, 32'h0, 2'd3, 1'b1);
      check("lat_not_yet", 128'(valid), 128'(0));
      check("lat_busy", 128'(empty), 128'(0));
      step();
      check("lane0", {valid, iaddr_q}, {1'b1, 32'h100});
      step();
      check("lane1", {valid, iaddr_q}, {1'b1, 32'h104});
      step();
      check("two_only", 128'(valid), 128'(0));
      check("two_empty", 128'(empty), 128'(1));

      // Backpressure holds the first lane stable.
      ready = 1'b0;
      push(2'b11, 2'b01, 3'd0, 3'd0, 32'h100, 32'h104, 5'd0, 32'h0, 2'd3, 1'b1);
      step();
      check("bp_first", {valid, iaddr_q}, {1'b1, 32'h100});
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold", {valid, iaddr_q, priv_q}, {1'b1, 32'h100, 2'd3});
      end
      ready = 1'b1;
      step();
      check("bp_next", {valid, iaddr_q}, {1'b1, 32'h104});
      step();
      check("bp_done", 128'(valid), 128'(0));
      wait_drain(20);

      // Sparse bundle with an exception on lane 1 only.
      push(2'b10, 2'b10, 3'd0, 3'd1, 32'h0, 32'h200, 5'd2, 32'hDEAD, 2'd1, 1'b1);
      step();
      check("sparse_fields", {valid, itype_q, cause_q, tval_q}, {1'b1, 3'd1, 5'd2, 32'hDEAD});
      step();
      check("sparse_single", 128'(valid), 128'(0));
      wait_drain(20);

      // An all-zero bundle is ignored.
      push(2'b00, 2'b11, 3'd1, 3'd1, 32'h300, 32'h304, 5'd1, 32'h1, 2'd1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("zero_bundle_empty", {valid, empty}, {1'b0, 1'b1});
         step();
      end

      // Overflow: four bundles fit, the fifth is dropped while stalled.
      ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         push(2'b11, 2'b11, 3'd2, 3'd3, 32'h1000 + 32'(k * 16), 32'h1004 + 32'(k * 16),
              5'(k), 32'(k), 2'd0, k < 4);
         if (k == 3) check("ovf_not_yet", 128'(overflow), 128'(0));
      end
      check("ovf_set", 128'(overflow), 128'(1));
`ifdef MURE_DROP_CNT_EN
      check("drop_cnt_one", 128'(drop_cnt), 128'(1));
`endif
      clear_ovf = 1'b1;
      push(2'b01, 2'b00, 3'd0, 3'd0, 32'h2000, 32'h0, 5'd0, 32'h0, 2'd0, 1'b0);
      clear_ovf = 1'b0;
      check("ovf_drop_wins", 128'(overflow), 128'(1));
`ifdef MURE_DROP_CNT_EN
      check("drop_cnt_clear_drop", 128'(drop_cnt), 128'(1));
`endif
      ready = 1'b1;
      wait_drain(40);
      clear_ovf = 1'b1;
      step();
      clear_ovf = 1'b0;
      check("ovf_cleared", 128'(overflow), 128'(0));
`ifdef MURE_DROP_CNT_EN
      check("drop_cnt_cleared", 128'(drop_cnt), 128'(0));
`endif

      // Full FIFO accepts a push in the cycle its head's last lane pops.
      ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         push(2'b11, 2'b00, 3'd0, 3'd0, 32'h3000 + 32'(k * 16), 32'h3004 + 32'(k * 16),
              5'd0, 32'h0, 2'd2, 1'b1);
      end
      ready = 1'b1;
      push(2'b11, 2'b10, 3'd0, 3'd0, 32'h3400, 32'h3404, 5'd0, 32'h0, 2'd2, 1'b1);
      check("full_pop_no_ovf", 128'(overflow), 128'(0));
      wait_drain(40);
      check("full_pop_ovf_end", 128'(overflow), 128'(0));

      // Reset mid-drain discards everything immediately.
      push(2'b11, 2'b00, 3'd0, 3'd0, 32'h4000, 32'h4004, 5'd0, 32'h0, 2'd0, 1'b1);
      push(2'b11, 2'b00, 3'd0, 3'd0, 32'h4010, 32'h4014, 5'd0, 32'h0, 2'd0, 1'b1);
      step();
      check("pre_rst_valid", 128'(valid), 128'(1));
      rst_n = 1'b0;
      #1;
      check("mid_rst_async", {valid, empty}, {1'b0, 1'b1});
      sb.delete();
      step();
      step();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("no_stale", {valid, empty}, {1'b0, 1'b1});
      end
      push(2'b11, 2'b11, 3'd0, 3'd0, 32'h5000, 32'h5004, 5'd0, 32'h0, 2'd3, 1'b1);
      wait_drain(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
